// File: rtl/dct_golden_checker.sv
// ---------------------------------------------------------------------------
// dct_golden_checker
//
// On-chip result checker for the 2-D DCT datapath. Each accepted output beat
// from the DCT column stage is paired with a golden vector fetched from an
// external synchronous-read memory. Every lane is compared as a signed value
// within a tolerance. The block keeps saturating per-lane-group error counts
// and captures the first failing beat of a run.
//
// Ports
//   clk_i              rising-edge clock
//   rst_ni             asynchronous active-low reset
//   start_i            one-cycle pulse, begins a run (only from IDLE or DONE)
//   dut_valid_i        dut_data_i carries a beat this cycle
//   dut_data_i         LANES signed samples, lane i at [i*W +: W]
//   gold_rd_en_o       golden memory read strobe (combinational)
//   gold_addr_o        golden memory read address (beat counter)
//   gold_data_i        golden vector, valid the cycle after gold_rd_en_o
//   busy_o             run in progress (RUN or DRAIN)
//   done_o             run finished, results final
//   err_cnt_o          per-group mismatching-beat counts, group g at [g*ERR_W +: ERR_W]
//   first_err_valid_o  a mismatch has been captured this run
//   first_err_addr_o   beat index of the first mismatch
//   first_err_mask_o   failing lanes of that beat
// ---------------------------------------------------------------------------
module dct_golden_checker #(
    parameter int LANES   = 16,
    parameter int W       = 12,
    parameter int NUM_VEC = 512,
    parameter int ADDR_W  = 9,
    parameter int GROUPS  = 2,
    parameter int TOL     = 0,
    parameter int ERR_W   = 16
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    start_i,
    input  logic                    dut_valid_i,
    input  logic [LANES*W-1:0]      dut_data_i,
    output logic                    gold_rd_en_o,
    output logic [ADDR_W-1:0]       gold_addr_o,
    input  logic [LANES*W-1:0]      gold_data_i,
    output logic                    busy_o,
    output logic                    done_o,
    output logic [GROUPS*ERR_W-1:0] err_cnt_o,
    output logic                    first_err_valid_o,
    output logic [ADDR_W-1:0]       first_err_addr_o,
    output logic [LANES-1:0]        first_err_mask_o
);

    localparam int                LPG       = LANES / GROUPS;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_VEC - 1);
    localparam logic [W:0]        TOL_MAG   = (W+1)'(TOL);
    localparam logic [ERR_W-1:0]  ERR_MAX   = '1;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN,
        DONE
    } state_e;

    state_e state_q, state_d;

    logic [ADDR_W-1:0]              beatCnt_q, beatCnt_d;
    logic                           cmpVld_q, cmpVld_d;
    logic [LANES*W-1:0]             cmpData_q, cmpData_d;
    logic [ADDR_W-1:0]              cmpAddr_q, cmpAddr_d;
    logic [GROUPS-1:0][ERR_W-1:0]   errCnt_q, errCnt_d;
    logic                           firstErrValid_q, firstErrValid_d;
    logic [ADDR_W-1:0]              firstErrAddr_q, firstErrAddr_d;
    logic [LANES-1:0]               firstErrMask_q, firstErrMask_d;

    logic                           startAcc;
    logic                           beatAcc;
    logic                           lastBeat;
    logic [LANES-1:0]               laneMiss;
    logic [GROUPS-1:0]              groupMiss;
    logic                           anyMiss;

    // A start is only honoured when no run is in flight; beats only count
    // while running, so dut_valid_i is ignored in every other state.
    assign startAcc = start_i && ((state_q == IDLE) || (state_q == DONE));
    assign beatAcc  = dut_valid_i && (state_q == RUN);
    assign lastBeat = beatAcc && (beatCnt_q == LAST_ADDR);

    // State register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic. DRAIN lasts exactly one cycle so the last beat's
    // compare lands before done rises.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (startAcc) state_d = RUN;
            RUN:     if (lastBeat) state_d = DRAIN;
            DRAIN:   state_d = DONE;
            DONE:    if (startAcc) state_d = RUN;
            default: state_d = IDLE;
        endcase
    end

    // State-decoded outputs.
    always_comb begin
        busy_o       = (state_q == RUN) || (state_q == DRAIN);
        done_o       = (state_q == DONE);
        gold_rd_en_o = beatAcc;
    end

    // Per-lane compare. Both operands are widened by one bit before the
    // subtraction so even full-scale opposite extremes cannot wrap.
    for (genvar i = 0; i < LANES; i++) begin : gLane
        logic signed [W:0] dutExt;
        logic signed [W:0] goldExt;
        logic signed [W:0] diff;
        logic        [W:0] diffMag;

        assign dutExt   = {cmpData_q[i*W+W-1], cmpData_q[i*W +: W]};
        assign goldExt  = {gold_data_i[i*W+W-1], gold_data_i[i*W +: W]};
        assign diff     = dutExt - goldExt;
        assign diffMag  = diff[W] ? -diff : diff;
        assign laneMiss[i] = cmpVld_q && (diffMag > TOL_MAG);
    end

    // Lanes are grouped contiguously; a group flags a beat if any of its
    // lanes failed.
    for (genvar g = 0; g < GROUPS; g++) begin : gGroup
        assign groupMiss[g] = |laneMiss[g*LPG +: LPG];
    end

    assign anyMiss = |laneMiss;

    // Next-state for the beat counter, compare stage and result registers.
    // A newly accepted start clears everything from the previous run; a start
    // can never coincide with a compare because compares only happen in RUN
    // or DRAIN.
    always_comb begin
        beatCnt_d       = beatCnt_q;
        cmpVld_d        = beatAcc;
        cmpData_d       = cmpData_q;
        cmpAddr_d       = cmpAddr_q;
        errCnt_d        = errCnt_q;
        firstErrValid_d = firstErrValid_q;
        firstErrAddr_d  = firstErrAddr_q;
        firstErrMask_d  = firstErrMask_q;

        if (startAcc) begin
            beatCnt_d       = '0;
            errCnt_d        = '0;
            firstErrValid_d = 1'b0;
            firstErrAddr_d  = '0;
            firstErrMask_d  = '0;
        end else begin
            if (beatAcc) begin
                beatCnt_d = (beatCnt_q == LAST_ADDR) ? '0 : beatCnt_q + 1'b1;
                cmpData_d = dut_data_i;
                cmpAddr_d = beatCnt_q;
            end
            for (int g = 0; g < GROUPS; g++) begin
                if (groupMiss[g] && (errCnt_q[g] != ERR_MAX)) begin
                    errCnt_d[g] = errCnt_q[g] + 1'b1;
                end
            end
            if (anyMiss && !firstErrValid_q) begin
                firstErrValid_d = 1'b1;
                firstErrAddr_d  = cmpAddr_q;
                firstErrMask_d  = laneMiss;
            end
        end
    end

    // Datapath and result registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            beatCnt_q       <= '0;
            cmpVld_q        <= 1'b0;
            cmpData_q       <= '0;
            cmpAddr_q       <= '0;
            errCnt_q        <= '0;
            firstErrValid_q <= 1'b0;
            firstErrAddr_q  <= '0;
            firstErrMask_q  <= '0;
        end else begin
            beatCnt_q       <= beatCnt_d;
            cmpVld_q        <= cmpVld_d;
            cmpData_q       <= cmpData_d;
            cmpAddr_q       <= cmpAddr_d;
            errCnt_q        <= errCnt_d;
            firstErrValid_q <= firstErrValid_d;
            firstErrAddr_q  <= firstErrAddr_d;
            firstErrMask_q  <= firstErrMask_d;
        end
    end

    assign gold_addr_o       = beatCnt_q;
    assign err_cnt_o         = errCnt_q;
    assign first_err_valid_o = firstErrValid_q;
    assign first_err_addr_o  = firstErrAddr_q;
    assign first_err_mask_o  = firstErrMask_q;

endmodule

// File: tb/tb_dct_golden_checker.sv
// ---------------------------------------------------------------------------
// tb_dct_golden_checker
//
// Directed bench for dct_golden_checker. Three instances share one stimulus
// stream: u0 uses the defaults, u1 uses TOL=1 and u2 uses ERR_W=2. Each has
// its own synchronous-read golden memory model fed from goldMem. Expected
// values are written by hand from the fault pattern placed in dutMem.
// ---------------------------------------------------------------------------
module tb_dct_golden_checker;

    localparam int LANES   = 16;
    localparam int W       = 12;
    localparam int NUM_VEC = 512;
    localparam int ADDR_W  = 9;
    localparam int GROUPS  = 2;
    localparam int DW      = LANES * W;

    logic              clk = 1'b0;
    logic              rstN;
    logic              start;
    logic              dutValid;
    logic [DW-1:0]     dutData;

    logic              rdEn0, rdEn1, rdEn2;
    logic [ADDR_W-1:0] addr0, addr1, addr2;
    logic [DW-1:0]     gold0, gold1, gold2;
    logic              busy0, busy1, busy2;
    logic              done0, done1, done2;
    logic [31:0]       errCnt0, errCnt1;
    logic [3:0]        errCnt2;
    logic              fev0, fev1, fev2;
    logic [ADDR_W-1:0] fea0, fea1, fea2;
    logic [15:0]       fem0, fem1, fem2;

    logic [DW-1:0]     goldMem [NUM_VEC];
    logic [DW-1:0]     dutMem  [NUM_VEC];

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    dct_golden_checker u0 (
        .clk_i(clk), .rst_ni(rstN), .start_i(start), .dut_valid_i(dutValid),
        .dut_data_i(dutData), .gold_rd_en_o(rdEn0), .gold_addr_o(addr0),
        .gold_data_i(gold0), .busy_o(busy0), .done_o(done0), .err_cnt_o(errCnt0),
        .first_err_valid_o(fev0), .first_err_addr_o(fea0), .first_err_mask_o(fem0)
    );

    dct_golden_checker #(.TOL(1)) u1 (
        .clk_i(clk), .rst_ni(rstN), .start_i(start), .dut_valid_i(dutValid),
        .dut_data_i(dutData), .gold_rd_en_o(rdEn1), .gold_addr_o(addr1),
        .gold_data_i(gold1), .busy_o(busy1), .done_o(done1), .err_cnt_o(errCnt1),
        .first_err_valid_o(fev1), .first_err_addr_o(fea1), .first_err_mask_o(fem1)
    );

    dct_golden_checker #(.ERR_W(2)) u2 (
        .clk_i(clk), .rst_ni(rstN), .start_i(start), .dut_valid_i(dutValid),
        .dut_data_i(dutData), .gold_rd_en_o(rdEn2), .gold_addr_o(addr2),
        .gold_data_i(gold2), .busy_o(busy2), .done_o(done2), .err_cnt_o(errCnt2),
        .first_err_valid_o(fev2), .first_err_addr_o(fea2), .first_err_mask_o(fem2)
    );

    // Golden memory models: synchronous read, data valid the cycle after the strobe.
    always @(posedge clk) if (rdEn0) gold0 <= goldMem[addr0];
    always @(posedge clk) if (rdEn1) gold1 <= goldMem[addr1];
    always @(posedge clk) if (rdEn2) gold2 <= goldMem[addr2];

    // Fill goldMem with a bounded pattern (-750..749) and make dutMem identical.
    task automatic initPattern();
        for (int b = 0; b < NUM_VEC; b++) begin
            for (int l = 0; l < LANES; l++) begin
                goldMem[b][l*W +: W] = W'(((b * 37 + l * 101) % 1500) - 750);
            end
            dutMem[b] = goldMem[b];
        end
    endtask

    function automatic logic signed [W-1:0] goldLane(input int b, input int l);
        return goldMem[b][l*W +: W];
    endfunction

    function automatic void setDutLane(input int b, input int l, input logic signed [W-1:0] v);
        dutMem[b][l*W +: W] = v;
    endfunction

    // Plays one full run of dutMem. gap idle cycles follow every beat except
    // the last; a start pulse is dropped into the first gap after beat
    // midStartBeat; junkStart presents a corrupted beat in the start cycle.
    task automatic doRun(input int gap, input int midStartBeat, input bit junkStart,
                         output int busyCount, output int doneLag);
        busyCount = 0;
        doneLag   = 0;
        @(negedge clk);
        start    = 1'b1;
        dutValid = junkStart;
        dutData  = ~dutMem[0];
        #1;
        if (junkStart) begin
            total++;
            if (rdEn0 !== 1'b0) begin
                bad++;
                $display("[TB] FAIL start_rd_en got=%b want=0", rdEn0);
            end
        end
        @(negedge clk);
        start    = 1'b0;
        dutValid = 1'b0;
        if (busy0) busyCount++;
        total++;
        if (done0 !== 1'b0 || busy0 !== 1'b1 || errCnt0 !== 32'h0 || fev0 !== 1'b0) begin
            bad++;
            $display("[TB] FAIL run_entry got done=%b busy=%b err=%h fev=%b want done=0 busy=1 err=0 fev=0",
                     done0, busy0, errCnt0, fev0);
        end
        for (int b = 0; b < NUM_VEC; b++) begin
            dutValid = 1'b1;
            dutData  = dutMem[b];
            #1;
            total++;
            if (addr0 !== ADDR_W'(b) || rdEn0 !== 1'b1) begin
                bad++;
                $display("[TB] FAIL fetch beat=%0d got addr=%0d rd=%b want addr=%0d rd=1", b, addr0, rdEn0, b);
            end
            @(negedge clk);
            if (busy0) busyCount++;
            dutValid = 1'b0;
            if (b != NUM_VEC - 1) begin
                for (int g = 0; g < gap; g++) begin
                    if (b == midStartBeat && g == 0) start = 1'b1;
                    total++;
                    if (addr0 !== ADDR_W'(b + 1)) begin
                        bad++;
                        $display("[TB] FAIL gap_addr beat=%0d got=%0d want=%0d", b, addr0, b + 1);
                    end
                    @(negedge clk);
                    start = 1'b0;
                    if (busy0) busyCount++;
                end
            end
        end
        while (!done0 && doneLag < 20) begin
            doneLag++;
            @(negedge clk);
            if (busy0) busyCount++;
        end
        total++;
        if (done0 !== 1'b1 || doneLag != 1) begin
            bad++;
            $display("[TB] FAIL done_lag got done=%b lag=%0d want done=1 lag=1", done0, doneLag);
        end
    endtask

    task automatic test_reset();
        rstN     = 1'b0;
        start    = 1'b0;
        dutValid = 1'b1;
        dutData  = '0;
        repeat (2) @(negedge clk);
        total++;
        if (busy0 !== 1'b0 || done0 !== 1'b0 || rdEn0 !== 1'b0 || addr0 !== '0 || errCnt0 !== 32'h0 ||
            fev0 !== 1'b0 || fea0 !== '0 || fem0 !== 16'h0) begin
            bad++;
            $display("[TB] FAIL reset_values got busy=%b done=%b rd=%b addr=%0d err=%h fev=%b fea=%0d fem=%h want all 0",
                     busy0, done0, rdEn0, addr0, errCnt0, fev0, fea0, fem0);
        end
        rstN = 1'b1;
        @(negedge clk);
        total++;
        if (rdEn0 !== 1'b0 || busy0 !== 1'b0 || addr0 !== '0) begin
            bad++;
            $display("[TB] FAIL idle_valid_ignored got rd=%b busy=%b addr=%0d want 0 0 0", rdEn0, busy0, addr0);
        end
        dutValid = 1'b0;
    endtask

    task automatic test_all_match();
        int busyCount, doneLag;
        initPattern();
        doRun(0, -1, 1'b1, busyCount, doneLag);
        total++;
        if (errCnt0 !== 32'h0 || fev0 !== 1'b0 || errCnt1 !== 32'h0 || errCnt2 !== 4'h0) begin
            bad++;
            $display("[TB] FAIL all_match_err got u0=%h fev=%b u1=%h u2=%h want 0 0 0 0", errCnt0, fev0, errCnt1, errCnt2);
        end
        total++;
        if (busyCount != 513) begin
            bad++;
            $display("[TB] FAIL busy_cycles got=%0d want=513", busyCount);
        end
    endtask

    task automatic test_single_fault();
        int busyCount, doneLag;
        initPattern();
        setDutLane(37, 9, goldLane(37, 9) + 12'sd1);
        doRun(0, -1, 1'b0, busyCount, doneLag);
        total++;
        if (errCnt0 !== 32'h0001_0000 || fev0 !== 1'b1 || fea0 !== 9'd37 || fem0 !== 16'h0200) begin
            bad++;
            $display("[TB] FAIL single_fault got err=%h fev=%b fea=%0d fem=%h want 00010000 1 37 0200",
                     errCnt0, fev0, fea0, fem0);
        end
        total++;
        if (errCnt1 !== 32'h0 || fev1 !== 1'b0) begin
            bad++;
            $display("[TB] FAIL single_fault_tol1 got err=%h fev=%b want 0 0", errCnt1, fev1);
        end
    endtask

    task automatic test_hold_in_done();
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            dutValid = 1'b1;
            dutData  = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
            #1;
            total++;
            if (rdEn0 !== 1'b0 || done0 !== 1'b1) begin
                bad++;
                $display("[TB] FAIL done_ignores_valid got rd=%b done=%b want 0 1", rdEn0, done0);
            end
        end
        @(negedge clk);
        dutValid = 1'b0;
        total++;
        if (errCnt0 !== 32'h0001_0000 || fea0 !== 9'd37 || fem0 !== 16'h0200 || fev0 !== 1'b1) begin
            bad++;
            $display("[TB] FAIL results_hold got err=%h fea=%0d fem=%h fev=%b want 00010000 37 0200 1",
                     errCnt0, fea0, fem0, fev0);
        end
    endtask

    task automatic test_tolerance();
        int busyCount, doneLag;
        initPattern();
        for (int b = 0; b < NUM_VEC; b++) setDutLane(b, 0, goldLane(b, 0) - 12'sd1);
        setDutLane(100, 0, goldLane(100, 0) - 12'sd2);
        doRun(0, -1, 1'b0, busyCount, doneLag);
        total++;
        if (errCnt1 !== 32'h0000_0001 || fev1 !== 1'b1 || fea1 !== 9'd100 || fem1 !== 16'h0001) begin
            bad++;
            $display("[TB] FAIL tol1_run got err=%h fev=%b fea=%0d fem=%h want 00000001 1 100 0001",
                     errCnt1, fev1, fea1, fem1);
        end
        total++;
        if (errCnt0 !== 32'h0000_0200 || fea0 !== 9'd0 || fem0 !== 16'h0001) begin
            bad++;
            $display("[TB] FAIL tol0_run got err=%h fea=%0d fem=%h want 00000200 0 0001", errCnt0, fea0, fem0);
        end
        total++;
        if (errCnt2 !== 4'b0011) begin
            bad++;
            $display("[TB] FAIL sat_all_beats got=%b want=0011", errCnt2);
        end
    endtask

    task automatic test_extremes();
        int busyCount, doneLag;
        initPattern();
        goldMem[0][5*W +: W] = 12'h7FF;
        dutMem[0][5*W +: W]  = 12'h800;
        goldMem[1][6*W +: W] = 12'h800;
        dutMem[1][6*W +: W]  = 12'h7FF;
        doRun(0, -1, 1'b0, busyCount, doneLag);
        total++;
        if (errCnt1 !== 32'h0000_0002 || fea1 !== 9'd0 || fem1 !== 16'h0020) begin
            bad++;
            $display("[TB] FAIL extremes got err=%h fea=%0d fem=%h want 00000002 0 0020", errCnt1, fea1, fem1);
        end
    endtask

    task automatic test_multi_fault();
        int busyCount, doneLag;
        initPattern();
        setDutLane(5, 3, goldLane(5, 3) + 12'sd1);
        setDutLane(5, 12, goldLane(5, 12) + 12'sd1);
        setDutLane(6, 3, goldLane(6, 3) + 12'sd1);
        setDutLane(6, 12, goldLane(6, 12) + 12'sd1);
        setDutLane(6, 4, goldLane(6, 4) + 12'sd1);
        doRun(0, -1, 1'b0, busyCount, doneLag);
        total++;
        if (errCnt0 !== 32'h0002_0002 || fea0 !== 9'd5 || fem0 !== 16'h1008) begin
            bad++;
            $display("[TB] FAIL multi_fault got err=%h fea=%0d fem=%h want 00020002 5 1008", errCnt0, fea0, fem0);
        end
        total++;
        if (errCnt2 !== 4'b1010) begin
            bad++;
            $display("[TB] FAIL multi_fault_errw2 got=%b want=1010", errCnt2);
        end
    endtask

    task automatic test_saturation();
        int busyCount, doneLag;
        initPattern();
        for (int k = 1; k <= 5; k++) setDutLane(k * 10, 2, goldLane(k * 10, 2) + 12'sd5);
        doRun(0, -1, 1'b0, busyCount, doneLag);
        total++;
        if (errCnt2 !== 4'b0011 || fea2 !== 9'd10 || fem2 !== 16'h0004) begin
            bad++;
            $display("[TB] FAIL saturation got err=%b fea=%0d fem=%h want 0011 10 0004", errCnt2, fea2, fem2);
        end
        total++;
        if (errCnt0 !== 32'h0000_0005) begin
            bad++;
            $display("[TB] FAIL five_beats got=%h want=00000005", errCnt0);
        end
    endtask

    task automatic test_gapped();
        int busyCount, doneLag;
        initPattern();
        setDutLane(37, 9, goldLane(37, 9) + 12'sd1);
        doRun(2, 100, 1'b0, busyCount, doneLag);
        total++;
        if (errCnt0 !== 32'h0001_0000 || fev0 !== 1'b1 || fea0 !== 9'd37 || fem0 !== 16'h0200) begin
            bad++;
            $display("[TB] FAIL gapped got err=%h fev=%b fea=%0d fem=%h want 00010000 1 37 0200",
                     errCnt0, fev0, fea0, fem0);
        end
    endtask

    task automatic test_reset_midrun();
        int busyCount, doneLag;
        initPattern();
        setDutLane(37, 9, goldLane(37, 9) + 12'sd1);
        setDutLane(300, 1, goldLane(300, 1) + 12'sd1);
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int b = 0; b < 200; b++) begin
            dutValid = 1'b1;
            dutData  = dutMem[b];
            @(negedge clk);
        end
        total++;
        if (errCnt0 !== 32'h0001_0000 || addr0 !== 9'd200 || busy0 !== 1'b1) begin
            bad++;
            $display("[TB] FAIL pre_reset got err=%h addr=%0d busy=%b want 00010000 200 1", errCnt0, addr0, busy0);
        end
        rstN = 1'b0;
        #1;
        total++;
        if (busy0 !== 1'b0 || done0 !== 1'b0 || rdEn0 !== 1'b0 || addr0 !== '0 || errCnt0 !== 32'h0 ||
            fev0 !== 1'b0 || fea0 !== '0 || fem0 !== 16'h0) begin
            bad++;
            $display("[TB] FAIL midrun_reset got busy=%b done=%b rd=%b addr=%0d err=%h fev=%b fea=%0d fem=%h want all 0",
                     busy0, done0, rdEn0, addr0, errCnt0, fev0, fea0, fem0);
        end
        @(negedge clk);
        rstN     = 1'b1;
        dutValid = 1'b0;
        dutMem[37] = goldMem[37];
        doRun(0, -1, 1'b0, busyCount, doneLag);
        total++;
        if (errCnt0 !== 32'h0000_0001 || fev0 !== 1'b1 || fea0 !== 9'd300 || fem0 !== 16'h0002) begin
            bad++;
            $display("[TB] FAIL restart got err=%h fev=%b fea=%0d fem=%h want 00000001 1 300 0002",
                     errCnt0, fev0, fea0, fem0);
        end
    endtask

    initial begin
        test_reset();
        test_all_match();
        test_single_fault();
        test_hold_in_done();
        test_tolerance();
        test_extremes();
        test_multi_fault();
        test_saturation();
        test_gapped();
        test_reset_midrun();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/dct_golden_checker.md
# dct_golden_checker

Parametrised on-chip result checker for the 2-D DCT datapath. It accepts one multi-lane output beat per cycle from the DCT column stage and fetches the matching golden vector from a synchronous-read memory. It compares each lane as a signed value, within a configurable tolerance, and keeps saturating per-lane-group error counts plus first-failure capture. It sits beside the DCT top next to the input memory and replaces off-line comparison of truncated column outputs.

## Interface
- LANES, 16, samples per beat
- W, 12, signed sample width
- NUM_VEC, 512, beats per run; golden memory depth
- ADDR_W, 9, golden address width, ≥ clog2(NUM_VEC)
- GROUPS, 2, error-count groups; LANES % GROUPS == 0, lanes split contiguously (group g = lanes g·LANES/GROUPS …)
- TOL, 0, max |dut − gold| still counted as match
- ERR_W, 16, error counter width
- clk  in  1  clock, rising edge
- rstn  in  1  asynchronous active-low reset
- start  in  1  one-cycle pulse; begins a run (honoured in IDLE or DONE only)
- dut_valid  in  1  dut_data holds a beat this cycle
- dut_data  in  LANES·W  lane i at bits [i·W +: W], signed
- gold_rd_en  out  1  golden memory read strobe
- gold_addr  out  ADDR_W  golden read address
- gold_data  in  LANES·W  golden vector, valid the cycle after gold_rd_en
- busy  out  1  state RUN or DRAIN
- done  out  1  high in DONE until next accepted start
- err_cnt  out  GROUPS·ERR_W  group g at [g·ERR_W +: ERR_W]; mismatching beats per group
- first_err_valid  out  1  a mismatch has been captured this run
- first_err_addr  out  ADDR_W  beat index of first mismatch
- first_err_mask  out  LANES  failing lanes of that beat

## Operation
- FSM states: IDLE, RUN, DRAIN, DONE.
  - IDLE/DONE --start--> RUN. On entry: clear beat counter, err_cnt, first_err_*; drop done.
  - RUN: each cycle with dut_valid=1 is an accepted beat.
  - RUN --accepted beat with counter == NUM_VEC−1--> DRAIN.
  - DRAIN --1 cycle--> DONE.
- Fetch: gold_rd_en = dut_valid & (state==RUN), combinational. gold_addr = beat counter, registered. The counter increments per accepted beat and wraps to 0 after NUM_VEC−1.
- Alignment: accepted dut_data and its address are registered into a compare stage (cmp_vld, cmp_data, cmp_addr). Next cycle they are compared with gold_data.
- Lane compare: sign-extend both to W+1 bits and subtract. Lane mismatches when |diff| > TOL. The subtraction must not overflow.
- Group g counts +1 per compared beat having ≥1 mismatching lane in g. Counters saturate at 2^ERR_W−1.
- First failure: on the first compared beat with any mismatch, latch cmp_addr, the lane mask, and first_err_valid=1. Later mismatches do not overwrite it.
- dut_valid outside RUN is ignored: no read, no compare.
- start during RUN/DRAIN is ignored.
- Results (err_cnt, first_err_*) hold through DONE and IDLE until the next start.

## Timing
- Reset values: state IDLE; busy=0, done=0, gold_rd_en=0 (dut_valid ignored), gold_addr=0, err_cnt=0, first_err_valid=0, first_err_addr=0, first_err_mask=0, cmp_vld=0.
- Throughput: one beat per cycle, no backpressure. Gaps in dut_valid are allowed.
- Latency: a beat accepted at edge t is compared during cycle t→t+1. Its err_cnt / first_err_* update is visible after edge t+1.
- Last beat accepted at edge t: DRAIN during t→t+1, with the final compare in that cycle. DONE and done=1 from edge t+1, so all counts are final when done rises.
- start and dut_valid in the same cycle in IDLE: that beat is not accepted; the first accepted beat comes one cycle later.
- rstn low mid-run: immediate return to reset values. Partial results are discarded.

## Test plan
- All-match run: NUM_VEC=512 beats equal to golden, continuous valid -> err_cnt={0,0}, first_err_valid=0, done rises 1 cycle after the last beat edge, busy 513 cycles.
- Single fault: beat 37 lane 9 off by +1, TOL=0 -> err_cnt group1=1, group0=0, first_err_addr=37, first_err_mask=16'h0200.
- Tolerance: TOL=1, lane 0 diffs of −1 on all beats and −2 on beat 100 -> group0=1, first_err_addr=100; extremes dut=−2048 vs gold=+2047 flagged without overflow.
- Multiple faults: beats 5 and 6 fail lanes 3 and 12; beat 6 also fails lane 4 -> err_cnt={2,2}, first_err_addr=5, mask=16'h1008. ERR_W=2 with 5 failing beats in group0 -> saturates at 3.
- Gapped valid and ignored start: valid every third cycle, start pulsed mid-run -> same results as the continuous run; gold_addr advances only on accepted beats.
- Reset mid-run at beat 200 then restart -> all outputs return to reset values, the new run reports counts only from the new beats, and gold_addr restarts at 0.
